// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared defaults and FSM state type for the FIFO write arbiter
package fifo_arb_pkg;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin search: first set req at or after rr_ptr
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = NUM_REQ,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic          valid,
  output logic [PW-1:0] index
);

  logic [PW-1:0] w_cand;

  // Scan offsets high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    valid  = 1'b0;
    index  = '0;
    w_cand = '0;
    for (int off = N - 1; off >= 0; off--) begin
      w_cand = PW'((int'(rr_ptr) + off) % N);
      if (req[w_cand]) begin
        valid = 1'b1;
        index = w_cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin FIFO write arbiter with bounded locked bursts
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = fifo_arb_pkg::NUM_REQ,
  parameter int DATA_W    = fifo_arb_pkg::DATA_W,
  parameter int MAX_BURST = fifo_arb_pkg::MAX_BURST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      fifo_full,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data_in
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e    r_state;
  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] r_owner;
  logic [BW-1:0] r_beat_cnt;

  arb_state_e    w_state_nx;
  logic [PW-1:0] w_rr_ptr_nx;
  logic [PW-1:0] w_owner_nx;
  logic [BW-1:0] w_beat_nx;
  logic [BW-1:0] w_beat_inc;
  logic [NUM_REQ-1:0] w_gnt;
  logic          w_pick_valid;
  logic [PW-1:0] w_pick_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_REQ - 1)) ? '0 : p + PW'(1);
  endfunction

  rr_priority_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .valid  (w_pick_valid),
    .index  (w_pick_idx)
  );

  assign w_beat_inc = r_beat_cnt + BW'(1);

  always_comb begin
    w_state_nx  = r_state;
    w_rr_ptr_nx = r_rr_ptr;
    w_owner_nx  = r_owner;
    w_beat_nx   = r_beat_cnt;
    w_gnt       = '0;
    if (rst) begin
      w_state_nx  = ARB_IDLE;
      w_rr_ptr_nx = '0;
      w_owner_nx  = '0;
      w_beat_nx   = '0;
    end else if (!fifo_full) begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            w_gnt[w_pick_idx] = 1'b1;
            w_rr_ptr_nx       = ptr_inc(w_pick_idx);
            if (req_lock[w_pick_idx] && (MAX_BURST > 1)) begin
              w_state_nx = ARB_BURST;
              w_owner_nx = w_pick_idx;
              w_beat_nx  = BW'(1);
            end
          end
        end
        ARB_BURST: begin
          // A dropped req or lock ends the burst on a dead cycle with no grant.
          if (req[r_owner] && req_lock[r_owner]) begin
            w_gnt[r_owner] = 1'b1;
            w_beat_nx      = w_beat_inc;
            if (w_beat_inc == BW'(MAX_BURST)) begin
              w_state_nx  = ARB_IDLE;
              w_rr_ptr_nx = ptr_inc(r_owner);
              w_beat_nx   = '0;
            end
          end else begin
            w_state_nx  = ARB_IDLE;
            w_rr_ptr_nx = ptr_inc(r_owner);
            w_beat_nx   = '0;
          end
        end
        default: w_state_nx = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_state    <= w_state_nx;
    r_rr_ptr   <= w_rr_ptr_nx;
    r_owner    <= w_owner_nx;
    r_beat_cnt <= w_beat_nx;
  end

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) fifo_data_in = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign gnt        = w_gnt;
  assign fifo_wr_en = |w_gnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and random checks of fifo_wr_arbiter against a behavioural model
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  req_lock = '0;
  logic [31:0] req_data = 32'h44332211;
  logic        fifo_full = 1'b0;
  logic [3:0]  gnt;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;

  int n_cmp = 0;
  int n_err = 0;

  int m_burst = 0;
  int m_owner = 0;
  int m_beats = 0;
  int m_ptr   = 0;

  fifo_wr_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_lock     (req_lock),
    .req_data     (req_data),
    .fifo_full    (fifo_full),
    .gnt          (gnt),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: expected outputs this cycle from rules, then state after the coming edge.
  always @(negedge clk) begin
    int k;
    int found;
    logic [3:0] eg;
    logic [7:0] ed;
    eg = '0;
    found = 0;
    if (rst) begin
      m_burst = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
    end else if (!fifo_full) begin
      if (m_burst == 0) begin
        for (int o = 0; o < 4; o++) begin
          k = (m_ptr + o) % 4;
          if (found == 0 && req[k]) begin
            found = 1;
            eg[k] = 1'b1;
            m_ptr = (k + 1) % 4;
            if (req_lock[k]) begin
              m_burst = 1; m_owner = k; m_beats = 1;
            end
          end
        end
      end else begin
        if (req[m_owner] && req_lock[m_owner]) begin
          eg[m_owner] = 1'b1;
          m_beats = m_beats + 1;
        end
        if (!(req[m_owner] && req_lock[m_owner]) || m_beats == 4) begin
          m_burst = 0; m_ptr = (m_owner + 1) % 4; m_beats = 0;
        end
      end
    end
    ed = 8'h00;
    for (int i = 0; i < 4; i++) if (eg[i]) ed = req_data[i*8 +: 8];
    chk("model_gnt", 32'(gnt), 32'(eg));
    chk("model_wr_en", 32'(fifo_wr_en), 32'(eg != 0));
    chk("model_data", 32'(fifo_data_in), 32'(ed));
    chk("onehot0", 32'($countones(gnt) <= 1), 32'd1);
    chk("no_gnt_when_full", 32'(fifo_full && (gnt != 0)), 32'd0);
  end

  task automatic step(input logic s_rst, input logic [3:0] s_req, input logic [3:0] s_lock,
                      input logic s_full, input logic [3:0] eg, input logic [7:0] ed);
    @(posedge clk);
    #1;
    rst = s_rst; req = s_req; req_lock = s_lock; fifo_full = s_full;
    @(negedge clk);
    chk("lit_gnt", 32'(gnt), 32'(eg));
    chk("lit_data", 32'(fifo_data_in), 32'(ed));
    chk("lit_wr_en", 32'(fifo_wr_en), 32'(eg != 0));
  endtask

  initial begin
    // Reset with all requesters active: outputs forced low.
    step(1, 4'b1111, 4'b1111, 0, 4'b0000, 8'h00);
    step(1, 4'b1111, 4'b1111, 0, 4'b0000, 8'h00);

    // Plain round robin across all four requesters.
    for (int r = 0; r < 2; r++) begin
      step(0, 4'b1111, 4'b0000, 0, 4'b0001, 8'h11);
      step(0, 4'b1111, 4'b0000, 0, 4'b0010, 8'h22);
      step(0, 4'b1111, 4'b0000, 0, 4'b0100, 8'h33);
      step(0, 4'b1111, 4'b0000, 0, 4'b1000, 8'h44);
    end

    // FIFO full stalls, then resumes at the same pointer.
    step(0, 4'b0011, 4'b0000, 1, 4'b0000, 8'h00);
    step(0, 4'b0011, 4'b0000, 1, 4'b0000, 8'h00);
    step(0, 4'b0011, 4'b0000, 1, 4'b0000, 8'h00);
    step(0, 4'b0011, 4'b0000, 0, 4'b0001, 8'h11);
    step(0, 4'b0011, 4'b0000, 0, 4'b0010, 8'h22);

    // Locked burst of requester 2 capped at four beats, then pointer moves to 3 -> 0.
    step(0, 4'b0101, 4'b0100, 0, 4'b0100, 8'h33);
    step(0, 4'b0101, 4'b0100, 0, 4'b0100, 8'h33);
    step(0, 4'b0101, 4'b0100, 0, 4'b0100, 8'h33);
    step(0, 4'b0101, 4'b0100, 0, 4'b0100, 8'h33);
    step(0, 4'b0101, 4'b0100, 0, 4'b0001, 8'h11);
    step(0, 4'b0101, 4'b0100, 0, 4'b0100, 8'h33);
    step(0, 4'b0000, 4'b0000, 0, 4'b0000, 8'h00);

    // Owner 1 drops req after two beats: dead cycle, then search starts at 2.
    step(0, 4'b0010, 4'b0010, 0, 4'b0010, 8'h22);
    step(0, 4'b0010, 4'b0010, 0, 4'b0010, 8'h22);
    step(0, 4'b0101, 4'b0010, 0, 4'b0000, 8'h00);
    step(0, 4'b0101, 4'b0000, 0, 4'b0100, 8'h33);

    // Reset in the cycle of beat 2 aborts the burst; pointer restarts at 0.
    step(0, 4'b1000, 4'b1000, 0, 4'b1000, 8'h44);
    step(1, 4'b1111, 4'b1111, 0, 4'b0000, 8'h00);
    step(0, 4'b1111, 4'b0000, 0, 4'b0001, 8'h11);

    // Random stress: full toggles each cycle, all requesters locked.
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      fifo_full = c[0];
      req = 4'($urandom);
      req_lock = 4'b1111;
      req_data = $urandom;
    end

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-002 Parameter NUM_REQ SHALL be 4: number of write requesters.
REQ-003 Parameter DATA_W SHALL be 8: FIFO data width.
REQ-004 Parameter MAX_BURST SHALL be 4: maximum consecutive beats granted to one locked requester.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-007 Port req, input, NUM_REQ bits, SHALL be the per-requester write request.
REQ-008 Port req_lock, input, NUM_REQ bits, SHALL be the per-requester burst-hold request.
REQ-009 Port req_data, input, NUM_REQ*DATA_W bits, SHALL carry requester i's data in bits [i*DATA_W +: DATA_W].
REQ-010 Port fifo_full, input, 1 bit, SHALL be the downstream FIFO full flag.
REQ-011 Port gnt, output, NUM_REQ bits, SHALL be a one-hot-or-zero grant; a set bit means that requester's word is written this cycle.
REQ-012 Port fifo_wr_en, output, 1 bit, SHALL drive the FIFO write enable.
REQ-013 Port fifo_data_in, output, DATA_W bits, SHALL drive the FIFO write data.

Function
REQ-014 gnt, fifo_wr_en and fifo_data_in SHALL be combinational from the current state and inputs (0-cycle latency); fifo_wr_en SHALL equal OR of gnt.
REQ-015 fifo_data_in SHALL equal the granted requester's slice, or 0 when no grant.
REQ-016 No grant SHALL be issued in any cycle where fifo_full=1; all state SHALL hold in that cycle.
REQ-017 FSM states SHALL be ARB_IDLE and ARB_BURST.
REQ-018 ARB_IDLE: grant the first asserted req at or after rr_ptr, searching upward modulo NUM_REQ.
REQ-019 On an ARB_IDLE grant to index k: rr_ptr <= (k+1) mod NUM_REQ.
REQ-020 On an ARB_IDLE grant to index k with req_lock[k]=1: go to ARB_BURST, owner <= k, beat_cnt <= 1.
REQ-021 Exception to REQ-020: if MAX_BURST=1, the FSM SHALL stay in ARB_IDLE.
REQ-022 ARB_BURST: grant only owner, and only when req[owner]=1 and fifo_full=0; no other requester SHALL be granted.
REQ-023 ARB_BURST granted beat: beat_cnt increments.
REQ-024 ARB_BURST exit: if the post-increment beat_cnt equals MAX_BURST, go to ARB_IDLE next cycle.
REQ-025 ARB_BURST exit: if req[owner]=0 or req_lock[owner]=0, issue no grant that cycle and go to ARB_IDLE next cycle.
REQ-026 On every exit from ARB_BURST: rr_ptr <= (owner+1) mod NUM_REQ and beat_cnt <= 0.
REQ-027 fifo_full=1 in ARB_BURST SHALL stall without counting a beat or exiting.
REQ-028 beat_cnt width SHALL be clog2(MAX_BURST+1); rr_ptr and owner width SHALL be clog2(NUM_REQ).

Reset
REQ-029 While rst=1 at a clock edge, the next state SHALL be: state=ARB_IDLE, rr_ptr=0, owner=0, beat_cnt=0.
REQ-030 While rst=1, gnt=0, fifo_wr_en=0 and fifo_data_in=0 regardless of inputs.
REQ-031 Reset asserted mid-burst SHALL abort the burst with no grant in that cycle.

Structure
REQ-032 Package fifo_arb_pkg SHALL hold NUM_REQ, DATA_W, MAX_BURST defaults and the arb_state_e enum (ARB_IDLE, ARB_BURST).
REQ-033 The round-robin search SHALL be a combinational sub-module rr_priority_pick (inputs req, rr_ptr; outputs valid, index).

Verification
REQ-034 Scenario: reset, then req=4'b1111, lock=0, full=0 for 8 cycles -> gnt sequence 0001,0010,0100,1000 repeating; data matches each slice.
REQ-035 Scenario: req[2]=1 with lock[2]=1 held for 6 cycles, req[0]=1 throughout -> gnt=0100 for 4 cycles, then 0001; rr_ptr afterwards =3.
REQ-036 Scenario: fifo_full=1 for 3 cycles with req=4'b0011 -> gnt=0, fifo_wr_en=0; on full=0 grant resumes at the same rr_ptr.
REQ-037 Scenario: burst owner 1 drops req after 2 beats -> 1 idle cycle, then ARB_IDLE grants the next requester from index 2.
REQ-038 Scenario: rst=1 asserted during beat 2 of a burst -> same cycle gnt=0; after release, first grant follows rr_ptr=0.
REQ-039 Scenario: full toggling every cycle with 4 locked requesters, 200 random cycles -> never more than one gnt bit set, no grant while full, no burst exceeds 4 beats.
